// File: rtl/sb_pkg.sv
// Shared definitions for the store buffer.
// Contents: default address/data widths, RISC-V funct3 size codes for stores
// and loads, and the buffered-store entry record.
package sb_pkg;

   localparam int unsigned SB_ADDR_W = 9;
   localparam int unsigned SB_DATA_W = 32;

   // Store size codes
   localparam logic [2:0] FUNCT3_SB  = 3'b000;
   localparam logic [2:0] FUNCT3_SH  = 3'b001;
   localparam logic [2:0] FUNCT3_SW  = 3'b010;
   // Load size codes
   localparam logic [2:0] FUNCT3_LB  = 3'b000;
   localparam logic [2:0] FUNCT3_LH  = 3'b001;
   localparam logic [2:0] FUNCT3_LW  = 3'b010;
   localparam logic [2:0] FUNCT3_LBU = 3'b100;

   typedef struct packed {
      logic [SB_ADDR_W-1:0] addr;
      logic [SB_DATA_W-1:0] data;
      logic [2:0]           funct3;
   } sb_entry_t;

endpackage

// File: rtl/sb_addr_match.sv
// Youngest-match search over the pending store entries.
// Ports:
//   i_entries  - all entry slots, indexed by physical slot
//   i_valid    - per-slot occupancy mask
//   i_head     - slot of the oldest entry
//   i_ld_addr  - load byte address; compared at word granularity
//   o_hit_idx  - slot of the youngest matching entry
//   o_found    - at least one valid entry matches
//   o_size     - funct3 of the youngest matching entry
module sb_addr_match
   import sb_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned PTR_W = $clog2(DEPTH)
) (
   input  sb_entry_t [DEPTH-1:0] i_entries,
   input  logic [DEPTH-1:0]      i_valid,
   input  logic [PTR_W-1:0]      i_head,
   input  logic [SB_ADDR_W-1:0]  i_ld_addr,
   output logic [PTR_W-1:0]      o_hit_idx,
   output logic                  o_found,
   output logic [2:0]            o_size
);

   logic [PTR_W-1:0] w_idx;

   // Walk from oldest to youngest; later matches overwrite earlier ones, so
   // the surviving result is the youngest matching entry.
   always_comb begin
      o_hit_idx = '0;
      o_found   = 1'b0;
      o_size    = '0;
      w_idx     = '0;
      for (int k = 0; k < DEPTH; k++) begin
         w_idx = i_head + PTR_W'(k);
         if (i_valid[w_idx] &&
             (i_entries[w_idx].addr[SB_ADDR_W-1:2] == i_ld_addr[SB_ADDR_W-1:2])) begin
            o_found   = 1'b1;
            o_hit_idx = w_idx;
            o_size    = i_entries[w_idx].funct3;
         end
      end
   end

endmodule

// File: rtl/store_buffer.sv
// In-order store buffer between the MEM stage and data memory.
// Stores are queued and drained one per cycle whenever the memory port is not
// taken by a load. Loads are checked against the pending stores.
// Ports:
//   clk, rst                           - clock, async active-high reset
//   st_valid/st_addr/st_data/st_funct3 - incoming store; st_ready = not full
//   ld_valid/ld_addr                   - load lookup
//   ld_hit/ld_data                     - load forwarded from a pending SW
//   ld_conflict                        - load overlaps an unforwardable store
//   mem_busy                           - memory port taken by a load
//   mem_write/mem_addr/mem_wdata/mem_funct3 - drain request (head entry)
//   empty, count                       - occupancy
// Build option: STORE_BUFFER_FORWARD_EN enables forwarding from SW entries;
// without it every word-address match is reported as a conflict.
module store_buffer
   import sb_pkg::*;
#(
   parameter int unsigned DM_ADDRESS = 9,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned DEPTH      = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      st_valid,
   input  logic [DM_ADDRESS-1:0]     st_addr,
   input  logic [DATA_W-1:0]         st_data,
   input  logic [2:0]                st_funct3,
   output logic                      st_ready,
   input  logic                      ld_valid,
   input  logic [DM_ADDRESS-1:0]     ld_addr,
   output logic                      ld_hit,
   output logic [DATA_W-1:0]         ld_data,
   output logic                      ld_conflict,
   input  logic                      mem_busy,
   output logic                      mem_write,
   output logic [DM_ADDRESS-1:0]     mem_addr,
   output logic [DATA_W-1:0]         mem_wdata,
   output logic [2:0]                mem_funct3,
   output logic                      empty,
   output logic [$clog2(DEPTH):0]    count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   // The entry record in sb_pkg is fixed-width; reject mismatched overrides.
   if (DM_ADDRESS != SB_ADDR_W || DATA_W != SB_DATA_W) begin : g_width_check
      $error("store_buffer: DM_ADDRESS/DATA_W must match sb_pkg entry widths");
   end
   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
      $error("store_buffer: DEPTH must be a power of two, at least 2");
   end

   sb_entry_t [DEPTH-1:0] r_entries;
   logic [PTR_W-1:0]      r_head;
   logic [PTR_W-1:0]      r_tail;
   logic [CNT_W-1:0]      r_count;

   logic                  w_push;
   logic                  w_pop;
   logic [DEPTH-1:0]      w_valid;
   logic [PTR_W-1:0]      w_off;
   logic [PTR_W-1:0]      w_hit_idx;
   logic                  w_found;
   logic [2:0]            w_size;

   assign empty      = (r_count == '0);
   assign count      = r_count;
   // No bypass: a full buffer refuses a store even when the head drains.
   assign st_ready   = (r_count < CNT_W'(DEPTH));
   assign w_push     = st_valid && st_ready;
   assign mem_write  = !empty && !mem_busy;
   assign w_pop      = mem_write;
   assign mem_addr   = r_entries[r_head].addr;
   assign mem_wdata  = r_entries[r_head].data;
   assign mem_funct3 = r_entries[r_head].funct3;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_tail <= r_tail + PTR_W'(1);
         if (w_pop)  r_head <= r_head + PTR_W'(1);
         if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
         else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);
      end
   end

   // Payload is qualified by the occupancy mask, so it carries no reset.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_entries[r_tail] <= '{addr: st_addr, data: st_data, funct3: st_funct3};
      end
   end

   // A slot is live when its distance from the head (mod DEPTH) is below count.
   always_comb begin
      w_valid = '0;
      w_off   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         w_off      = PTR_W'(i) - r_head;
         w_valid[i] = (CNT_W'(w_off) < r_count);
      end
   end

   sb_addr_match #(
      .DEPTH (DEPTH),
      .PTR_W (PTR_W)
   ) u_match (
      .i_entries (r_entries),
      .i_valid   (w_valid),
      .i_head    (r_head),
      .i_ld_addr (ld_addr),
      .o_hit_idx (w_hit_idx),
      .o_found   (w_found),
      .o_size    (w_size)
   );

`ifdef STORE_BUFFER_FORWARD_EN
   always_comb begin
      ld_hit      = ld_valid && w_found && (w_size == FUNCT3_SW);
      ld_conflict = ld_valid && w_found && (w_size != FUNCT3_SW);
      ld_data     = ld_hit ? r_entries[w_hit_idx].data : '0;
   end
`else
   always_comb begin
      ld_hit      = 1'b0;
      ld_data     = '0;
      ld_conflict = ld_valid && w_found;
   end
`endif

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter DM_ADDRESS, default 9, meaning the data-memory byte-address width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning the store-data width.
REQ-003 SHALL have parameter DEPTH, default 4, meaning the number of entries (power of two, at least 2).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 SHALL have port st_valid, input, 1 bit: the MEM stage presents a store.
REQ-007 SHALL have ports st_addr (input, DM_ADDRESS bits), st_data (input, DATA_W bits) and st_funct3 (input, 3 bits): the store address, data and size code (SB=000, SH=001, SW=010).
REQ-008 SHALL have port st_ready, output, 1 bit: the buffer accepts a store this cycle.
REQ-009 SHALL have ports ld_valid (input, 1 bit) and ld_addr (input, DM_ADDRESS bits): the MEM stage performs a load.
REQ-010 SHALL have ports ld_hit (output, 1 bit) and ld_data (output, DATA_W bits): the load is satisfied by a forwarded word.
REQ-011 SHALL have port ld_conflict, output, 1 bit: the load overlaps a pending store that cannot be forwarded, and the pipeline must stall.
REQ-012 SHALL have port mem_busy, input, 1 bit: the data-memory port is used by a load this cycle.
REQ-013 SHALL have ports mem_write (output, 1 bit), mem_addr (output, DM_ADDRESS bits), mem_wdata (output, DATA_W bits) and mem_funct3 (output, 3 bits): the drain request to data memory.
REQ-014 SHALL have ports empty (output, 1 bit) and count (output, $clog2(DEPTH)+1 bits): the buffer occupancy.

Function
REQ-015 SHALL operate as an in-order FIFO, with a push when st_valid && st_ready.
REQ-016 SHALL drive st_ready = (count < DEPTH), with no same-cycle bypass when full, even if a pop occurs.
REQ-017 SHALL drive mem_write = !empty && !mem_busy combinationally, with mem_addr, mem_wdata and mem_funct3 taken from the head entry.
REQ-018 SHALL pop the head at the clock edge ending a cycle with mem_write=1, giving exactly one write per entry.
REQ-019 SHALL update count by +1 on a push only, by -1 on a pop only, and leave it unchanged on a simultaneous push and pop.
REQ-020 SHALL wrap the read and write pointers modulo DEPTH.
REQ-021 SHALL match a load to an entry by word address (addr[DM_ADDRESS-1:2]).
REQ-022 SHALL set ld_hit=1 and ld_data to the entry data when the youngest matching entry is an SW.
REQ-023 SHALL set ld_conflict=1 and ld_hit=0 when the youngest matching entry is an SB or SH.
REQ-024 SHALL drive ld_hit=0, ld_conflict=0 and ld_data=0 when ld_valid=0 or there is no match.
REQ-025 SHALL exclude a store being pushed in the same cycle from load matching, because matching uses registered entries only.
REQ-026 SHALL use the full-empty flag pair count==0 and count==DEPTH, so that no overflow or underflow is possible.

Reset
REQ-027 SHALL, while rst=1, force count=0, both pointers=0, empty=1, st_ready=1, mem_write=0, ld_hit=0 and ld_conflict=0.
REQ-028 SHALL discard all pending entries, without draining them, when rst is asserted mid-operation.
REQ-029 SHALL leave the entry payload registers not reset.

Configuration
REQ-030 SHALL, when macro STORE_BUFFER_FORWARD_EN is defined, forward loads per REQ-022 and REQ-023.
REQ-031 SHALL, when STORE_BUFFER_FORWARD_EN is undefined, tie ld_hit to 0, tie ld_data to 0, and assert ld_conflict for any word-address match regardless of store size.

Structure
REQ-032 SHALL place the entry struct (addr, data, funct3) and the funct3 constants (SB, SH, SW, LB, LH, LW, LBU) in shared package sb_pkg.
REQ-033 SHALL implement the youngest-match priority search in one sub-module, sb_addr_match, which takes the entries, valid mask, head pointer and load address and returns hit index, found and size.

Verification
REQ-034 SHALL cover: after rst, SW to 0x010 of 0xDEADBEEF with mem_busy=0 -> next cycle mem_write=1, mem_addr=0x010, mem_wdata=0xDEADBEEF, then empty=1.
REQ-035 SHALL cover: four SWs with mem_busy=1 held -> count=4, st_ready=0; then a fifth st_valid is not accepted; releasing mem_busy -> four writes issued in push order.
REQ-036 SHALL cover: pending SW 0x020=0x12345678 and SW 0x020=0xCAFEF00D, mem_busy=1, load 0x022 -> ld_hit=1, ld_data=0xCAFEF00D.
REQ-037 SHALL cover: pending SB to 0x031, load 0x030 -> ld_conflict=1, ld_hit=0; after drain -> ld_conflict=0.
REQ-038 SHALL cover: count=3 with simultaneous push and pop -> count stays 3 and the pointers wrap correctly across index DEPTH-1.
REQ-039 SHALL cover: rst asserted with count=2 -> count=0 and mem_write=0 immediately, and no writes issued after release.
